// File: rtl/draw_cursor_sprite_if.sv
// VGA timing bundle passed between pixel-pipeline stages.
// IN  : consumer side (a stage reading timing from the previous stage)
// OUT : producer side (a stage driving timing to the next stage)
interface vga_if;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  modport IN  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport OUT (output hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/draw_cursor_sprite.sv
// Cursor-sprite overlay stage. Draws a SPRITE_W x SPRITE_H sprite from an
// internal writable RAM, magnified by 2**SCALE_LOG2, at the mouse position.
// Texels equal to KEY_COLOUR are transparent. Position/enable are latched at
// the rising edge of vblnk so the cursor never tears mid-frame.
// Ports:
//   clk, rst        pixel clock, synchronous active-high reset
//   in / out        VGA timing in, same timing delayed 2 cycles out
//   rgb_in/rgb_out  background pixel in, composited pixel out (2 cycles)
//   xpos, ypos      cursor top-left from the mouse block
//   cursor_en       show cursor (sampled once per frame)
//   spr_we/waddr/wdata  sprite RAM write port, row-major texel address.
//                   spr_waddr carries one spare bit when the texel count is
//                   a power of two, so out-of-range writes can be rejected.
module draw_cursor_sprite #(
  parameter int SPRITE_W   = 16,
  parameter int SPRITE_H   = 16,
  parameter int SCALE_LOG2 = 0,
  parameter int RGB_W      = 12,
  parameter logic [RGB_W-1:0] KEY_COLOUR = 12'hF0F,
  parameter int H_ACTIVE   = 1024,
  parameter int V_ACTIVE   = 768,
  localparam int N    = SPRITE_W * SPRITE_H,
  localparam int AW   = $clog2(N),
  localparam int WA_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  vga_if.IN                in,
  vga_if.OUT               out,
  input  logic [RGB_W-1:0] rgb_in,
  output logic [RGB_W-1:0] rgb_out,
  input  logic [11:0]      xpos,
  input  logic [11:0]      ypos,
  input  logic             cursor_en,
  input  logic             spr_we,
  input  logic [WA_W-1:0]  spr_waddr,
  input  logic [RGB_W-1:0] spr_wdata
);

  localparam int SW_S = SPRITE_W << SCALE_LOG2;
  localparam int SH_S = SPRITE_H << SCALE_LOG2;

  typedef struct packed {
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
  } vga_t;

  // ---------------- frame latch ----------------
  logic        vblnk_q;
  logic        vblnk_rise;
  logic [11:0] x_l, y_l;
  logic        en_l;

  assign vblnk_rise = in.vblnk & ~vblnk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q <= 1'b0;
      x_l     <= '0;
      y_l     <= '0;
      en_l    <= 1'b0;
    end else begin
      vblnk_q <= in.vblnk;
      if (vblnk_rise) begin
        x_l  <= (xpos > 12'(H_ACTIVE - 1)) ? 12'(H_ACTIVE - 1) : xpos;
        y_l  <= (ypos > 12'(V_ACTIVE - 1)) ? 12'(V_ACTIVE - 1) : ypos;
        en_l <= cursor_en;
      end
    end
  end

  // ---------------- stage 1: hit test + texel address ----------------
  logic signed [12:0] dx, dy;
  logic               in_x, in_y, hit;
  logic [11:0]        col, row;
  logic [AW-1:0]      raddr;
  vga_t               t_in;

  // Zero-extended 13-bit difference: bit 12 set means the pixel is left of /
  // above the cursor, so no wrap-around hit is possible at column/line 0.
  assign dx   = $signed({1'b0, in.hcount}) - $signed({1'b0, x_l});
  assign dy   = $signed({1'b0, in.vcount}) - $signed({1'b0, y_l});
  assign in_x = ~dx[12] && (dx[11:0] < 12'(SW_S));
  assign in_y = ~dy[12] && (dy[11:0] < 12'(SH_S));
  assign hit  = en_l & ~in.hblnk & ~in.vblnk & in_x & in_y;
  assign col  = dx[11:0] >> SCALE_LOG2;
  assign row  = dy[11:0] >> SCALE_LOG2;
  // Address forced to 0 on a miss keeps the RAM index in range.
  assign raddr = hit ? AW'(32'(row) * SPRITE_W + 32'(col)) : '0;

  assign t_in = '{hcount: in.hcount, vcount: in.vcount, hsync: in.hsync,
                  vsync: in.vsync, hblnk: in.hblnk, vblnk: in.vblnk};

  // ---------------- sprite RAM ----------------
  // Power-up content is fully transparent; the RAM is never reset.
  logic [RGB_W-1:0] mem [N] = '{default: KEY_COLOUR};
  logic [RGB_W-1:0] texel;

  // Read and write share one process: the read samples the pre-edge array,
  // so a same-cycle write to the read address returns the old texel.
  always_ff @(posedge clk) begin
    if (spr_we && (spr_waddr < WA_W'(N)))
      mem[spr_waddr[AW-1:0]] <= spr_wdata;
    texel <= mem[raddr];
  end

  // ---------------- pipeline registers ----------------
  vga_t             t1, t2;
  logic             hit_q, blank_q;
  logic [RGB_W-1:0] rgb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      t1      <= '0;
      t2      <= '0;
      hit_q   <= 1'b0;
      blank_q <= 1'b0;
      rgb_q   <= '0;
      rgb_out <= '0;
    end else begin
      t1      <= t_in;
      hit_q   <= hit;
      blank_q <= in.hblnk | in.vblnk;
      rgb_q   <= rgb_in;
      t2      <= t1;
      rgb_out <= blank_q ? '0 :
                 (hit_q && (texel != KEY_COLOUR)) ? texel : rgb_q;
    end
  end

  assign out.hcount = t2.hcount;
  assign out.vcount = t2.vcount;
  assign out.hsync  = t2.hsync;
  assign out.vsync  = t2.vsync;
  assign out.hblnk  = t2.hblnk;
  assign out.vblnk  = t2.vblnk;

endmodule

// File: tb/tb_draw_cursor_sprite.sv
module tb_draw_cursor_sprite;
  localparam int SW = 16, SH = 16, N = 256;
  localparam logic [11:0] KEY = 12'hF0F;
  localparam int BG = -1, SKIP = -2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_if vin();
  vga_if vo0();
  vga_if vo1();

  logic [11:0] rgb_in = '0, rgb0, rgb1, xpos = '0, ypos = '0;
  logic        cursor_en = 1'b0, spr_we = 1'b0;
  logic [8:0]  spr_waddr = '0;
  logic [11:0] spr_wdata = '0;

  draw_cursor_sprite #(.SCALE_LOG2(0)) dut0 (
    .clk(clk), .rst(rst), .in(vin), .out(vo0), .rgb_in(rgb_in), .rgb_out(rgb0),
    .xpos(xpos), .ypos(ypos), .cursor_en(cursor_en), .spr_we(spr_we),
    .spr_waddr(spr_waddr), .spr_wdata(spr_wdata));

  draw_cursor_sprite #(.SCALE_LOG2(1)) dut1 (
    .clk(clk), .rst(rst), .in(vin), .out(vo1), .rgb_in(rgb_in), .rgb_out(rgb1),
    .xpos(xpos), .ypos(ypos), .cursor_en(cursor_en), .spr_we(spr_we),
    .spr_waddr(spr_waddr), .spr_wdata(spr_wdata));

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [11:0] h, v;
    logic        hs, vs, hb, vb;
    logic [11:0] r0, r1;
  } exp_t;

  logic [11:0] mem [N];
  int   lx = 0, ly = 0;
  bit   len = 0, vq = 0;
  exp_t q0 = '0, q1 = '0;
  int   n_chk = 0, n_fail = 0;

  // What the screen must show at (h,v) for magnification 2**s.
  function automatic logic [11:0] pix(input int s, input int h, input int v,
                                      input bit blank, input logic [11:0] bgc);
    int dx, dy;
    logic [11:0] t;
    dx = h - lx;
    dy = v - ly;
    if (blank) return 12'h000;
    if (len && dx >= 0 && dx < (SW << s) && dy >= 0 && dy < (SH << s)) begin
      t = mem[(dy >> s) * SW + (dx >> s)];
      if (t != KEY) return t;
    end
    return bgc;
  endfunction

  initial begin
    exp_t e;
    foreach (mem[i]) mem[i] = KEY;
    forever begin
      @(posedge clk);
      if (rst) begin
        q0 = '0; q1 = '0;
        lx = 0; ly = 0; len = 0; vq = 0;
      end else begin
        e.h  = vin.hcount; e.v = vin.vcount;
        e.hs = vin.hsync;  e.vs = vin.vsync;
        e.hb = vin.hblnk;  e.vb = vin.vblnk;
        e.r0 = pix(0, vin.hcount, vin.vcount, vin.hblnk | vin.vblnk, rgb_in);
        e.r1 = pix(1, vin.hcount, vin.vcount, vin.hblnk | vin.vblnk, rgb_in);
        q1 = q0; q0 = e;
        if (vin.vblnk && !vq) begin
          lx  = (xpos > 12'd1023) ? 1023 : int'(xpos);
          ly  = (ypos > 12'd767)  ? 767  : int'(ypos);
          len = cursor_en;
        end
        vq = vin.vblnk;
      end
      // read-first: the pixel above saw the pre-write texel
      if (spr_we && spr_waddr < 9'(N)) mem[spr_waddr[7:0]] = spr_wdata;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      n_chk++;
      if ({vo0.hcount, vo0.vcount, vo0.hsync, vo0.vsync, vo0.hblnk, vo0.vblnk, rgb0} !==
          {q1.h, q1.v, q1.hs, q1.vs, q1.hb, q1.vb, q1.r0}) begin
        n_fail++;
        $display("FAIL cyc_dut0 t=%0t: got h%0d v%0d s%b%b b%b%b rgb %h, expected h%0d v%0d s%b%b b%b%b rgb %h",
                 $time, vo0.hcount, vo0.vcount, vo0.hsync, vo0.vsync, vo0.hblnk, vo0.vblnk, rgb0,
                 q1.h, q1.v, q1.hs, q1.vs, q1.hb, q1.vb, q1.r0);
      end
      n_chk++;
      if ({vo1.hcount, vo1.vcount, vo1.hsync, vo1.vsync, vo1.hblnk, vo1.vblnk, rgb1} !==
          {q1.h, q1.v, q1.hs, q1.vs, q1.hb, q1.vb, q1.r1}) begin
        n_fail++;
        $display("FAIL cyc_dut1 t=%0t: got h%0d v%0d rgb %h, expected h%0d v%0d rgb %h",
                 $time, vo1.hcount, vo1.vcount, rgb1, q1.h, q1.v, q1.r1);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic lit(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int h, input int v);
    @(negedge clk);
    vin.hcount = 12'(h);
    vin.vcount = 12'(v);
    vin.hblnk  = (h >= 1024);
    vin.vblnk  = (v >= 768);
    vin.hsync  = (h >= 1048 && h < 1184);
    vin.vsync  = (v >= 771 && v < 777);
    rgb_in     = 12'($urandom);
    spr_we     = 1'b0;
  endtask

  task automatic wr(input int a, input logic [11:0] d);
    drive($urandom_range(0, 1300), $urandom_range(0, 800));
    spr_we = 1'b1; spr_waddr = 9'(a); spr_wdata = d;
  endtask

  task automatic vblank();
    drive(5, 700);
    repeat (3) drive(1100, 770);
    drive(0, 0);
  endtask

  // Present one pixel (optionally with a same-cycle write), then check the
  // composited value two cycles later against a literal (BG = rgb_in).
  task automatic pin(input string nm, input int h, input int v, input int e0, input int e1,
                     input bit we = 0, input int wa = 0, input logic [11:0] wd = '0);
    logic [11:0] bgc;
    drive(h, v);
    bgc = rgb_in;
    if (we) begin spr_we = 1'b1; spr_waddr = 9'(wa); spr_wdata = wd; end
    @(negedge clk);
    spr_we = 1'b0;
    @(negedge clk);
    if (e0 != SKIP) lit({nm, "_s0"}, rgb0, (e0 == BG) ? bgc : 12'(e0));
    if (e1 != SKIP) lit({nm, "_s1"}, rgb1, (e1 == BG) ? bgc : 12'(e1));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int px, py, r;
    vin.hcount = '0; vin.vcount = '0; vin.hsync = 0; vin.vsync = 0;
    vin.hblnk = 0; vin.vblnk = 0;
    repeat (3) @(negedge clk);
    lit("reset_rgb", rgb0, 12'h000);
    lit("reset_hcount", vo0.hcount, 12'h000);
    rst = 1'b0;

    // all texels green, cursor at (100,50)
    for (int i = 0; i < N; i++) wr(i, 12'h0F0);
    xpos = 12'd100; ypos = 12'd50; cursor_en = 1'b1;
    vblank();
    for (int v = 48; v < 68; v++)
      for (int h = 96; h < 121; h++) drive(h, v);
    pin("green_tl", 100, 50, 12'h0F0, 12'h0F0);
    pin("green_br", 115, 65, 12'h0F0, 12'h0F0);
    pin("right_of", 116, 50, BG, 12'h0F0);
    pin("below", 100, 66, BG, 12'h0F0);
    pin("s1_right_of", 132, 50, BG, BG);
    pin("left_of", 99, 50, BG, BG);

    // transparent texel 0, rest white
    wr(0, KEY);
    for (int i = 1; i < N; i++) wr(i, 12'hFFF);
    vblank();
    pin("hole", 100, 50, BG, BG);
    pin("hole_edge", 101, 50, 12'hFFF, BG);
    pin("s1_hole", 101, 51, 12'hFFF, BG);
    pin("s1_past_hole", 102, 50, 12'hFFF, 12'hFFF);

    // mid-frame move only takes effect after the next vblank rise
    drive(120, 60);
    xpos = 12'd300;
    pin("move_old", 103, 50, 12'hFFF, 12'hFFF);
    pin("move_new_early", 303, 50, BG, BG);
    vblank();
    pin("move_new", 303, 50, 12'hFFF, 12'hFFF);
    pin("move_old_gone", 103, 50, BG, BG);

    // clamp to the bottom-right corner
    wr(0, 12'h0F0);
    xpos = 12'd4000; ypos = 12'd4000;
    vblank();
    pin("clamp_px", 1023, 767, 12'h0F0, 12'h0F0);
    pin("clamp_hblank", 1024, 767, 12'h000, 12'h000);
    pin("clamp_vblank", 1023, 768, 12'h000, 12'h000);
    pin("no_wrap", 0, 0, BG, BG);
    pin("clamp_left", 1022, 767, BG, BG);

    // read/write collision on texel 5, and an out-of-range write
    xpos = 12'd100; ypos = 12'd50;
    vblank();
    pin("rw_old", 105, 50, 12'hFFF, 12'hFFF, 1'b1, 5, 12'h00F);
    vblank();
    pin("rw_new", 105, 50, 12'h00F, 12'hFFF);
    pin("rw_new_s1", 110, 50, 12'hFFF, 12'h00F);
    wr(256, 12'h123);
    pin("oob_write", 100, 50, 12'h0F0, 12'h0F0);

    // reset mid-line hides the cursor until the next vblank rise
    drive(100, 50);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      lit("rst_rgb", rgb0, 12'h000);
      lit("rst_vcount", vo1.vcount, 12'h000);
    end
    rst = 1'b0;
    pin("hidden_after_rst", 100, 50, BG, BG);
    vblank();
    pin("shown_after_vbl", 100, 50, 12'h0F0, 12'h0F0);

    // randomized traffic checked by the per-cycle compare
    px = 100; py = 50;
    for (int it = 0; it < 4000; it++) begin
      r = $urandom_range(0, 99);
      if (r < 2) vblank();
      else if (r < 5) begin
        case ($urandom_range(0, 2))
          0: begin px = $urandom_range(0, 1100); py = $urandom_range(0, 800); end
          1: begin px = 4000; py = $urandom_range(700, 4095); end
          default: begin px = $urandom_range(0, 40); py = $urandom_range(0, 40); end
        endcase
        drive($urandom_range(0, 1300), $urandom_range(0, 800));
        xpos = 12'(px); ypos = 12'(py);
      end else if (r < 7) begin
        drive($urandom_range(0, 1300), $urandom_range(0, 800));
        cursor_en = 1'($urandom);
      end else if (r < 15)
        wr($urandom_range(0, 300), ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom));
      else if (r < 16) begin
        drive($urandom_range(0, 1300), $urandom_range(0, 800));
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) drive($urandom_range(0, 1300), 100);
        rst = 1'b0;
      end else begin
        int cx, cy;
        cx = (px > 1023) ? 1023 : px;
        cy = (py > 767) ? 767 : py;
        if (r < 80) drive(cx + $urandom_range(0, 40) - 4 + 4 * int'(cx < 4),
                          cy + $urandom_range(0, 40) - 4 + 4 * int'(cy < 4));
        else drive($urandom_range(0, 1343), $urandom_range(0, 805));
      end
    end
    repeat (3) drive(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
